// File: rtl/spi_calc_master.sv
// spi_calc_master: SPI mode-0 master (MSB first) for the calculator link: handshake, operands, opcode, result.
// Optional macro SPI_HS_RETRY_EN: retry a failed handshake up to HS_RETRIES times before aborting.
module spi_calc_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  HS_REQ     = 8'hAA,
    parameter logic [7:0]  HS_ACK     = 8'hBB,
    parameter int unsigned RESULT_W   = 4,
    parameter int unsigned HS_RETRIES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          num1,
    input  logic [3:0]          num2,
    input  logic [1:0]          operacion,
    output logic                busy,
    output logic                done,
    output logic                hs_error,
    output logic                LED_handshake,
    output logic [RESULT_W-1:0] resultado,
    output logic                SCLK,
    output logic                CS,
    output logic                MOSI,
    input  logic                MISO
);
    localparam int unsigned MAXB  = (RESULT_W > 8) ? RESULT_W : 8;
    localparam int unsigned BIT_W = $clog2(MAXB + 1);
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);
`ifdef SPI_HS_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(HS_RETRIES + 2);
`endif

    typedef enum logic [3:0] {
        IDLE, HS_TX, HS_RX, TX_NUM1, TX_NUM2, TX_OP, RX_RES, FINISH
`ifdef SPI_HS_RETRY_EN
        , HS_WAIT
`endif
    } state_t;

    state_t              state, state_n;
    logic                cs_n, sclk_n, busy_n, done_n, hs_error_n, led_n;
    logic [RESULT_W-1:0] resultado_n;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [7:0]          tx_sr, tx_n;
    logic [MAXB-1:0]     rx_sr, rx_n;
    logic [3:0]          n1_q, n1_n, n2_q, n2_n;
    logic [1:0]          op_q, op_n;
    logic                half_end;
`ifdef SPI_HS_RETRY_EN
    logic [RETRY_W-1:0]  retry_cnt, retry_n;
`endif

    // The current bit always sits in tx_sr[7]; receive fields load zeros so MOSI idles low.
    assign MOSI = tx_sr[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            CS            <= 1'b1;
            SCLK          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hs_error      <= 1'b0;
            LED_handshake <= 1'b0;
            resultado     <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            n1_q          <= '0;
            n2_q          <= '0;
            op_q          <= '0;
`ifdef SPI_HS_RETRY_EN
            retry_cnt     <= '0;
`endif
        end else begin
            state         <= state_n;
            CS            <= cs_n;
            SCLK          <= sclk_n;
            busy          <= busy_n;
            done          <= done_n;
            hs_error      <= hs_error_n;
            LED_handshake <= led_n;
            resultado     <= resultado_n;
            div_cnt       <= div_n;
            bit_cnt       <= bit_n;
            tx_sr         <= tx_n;
            rx_sr         <= rx_n;
            n1_q          <= n1_n;
            n2_q          <= n2_n;
            op_q          <= op_n;
`ifdef SPI_HS_RETRY_EN
            retry_cnt     <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cs_n        = CS;
        sclk_n      = SCLK;
        busy_n      = busy;
        done_n      = 1'b0;
        hs_error_n  = hs_error;
        led_n       = LED_handshake;
        resultado_n = resultado;
        div_n       = div_cnt;
        bit_n       = bit_cnt;
        tx_n        = tx_sr;
        rx_n        = rx_sr;
        n1_n        = n1_q;
        n2_n        = n2_q;
        op_n        = op_q;
`ifdef SPI_HS_RETRY_EN
        retry_n     = retry_cnt;
`endif
        half_end    = (div_cnt == DIV_W'(CLK_DIV - 1));

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = HS_TX;
                    cs_n       = 1'b0;
                    busy_n     = 1'b1;
                    hs_error_n = 1'b0;
                    led_n      = 1'b0;
                    div_n      = '0;
                    bit_n      = BIT_W'(8);
                    tx_n       = HS_REQ;
                    n1_n       = num1;
                    n2_n       = num2;
                    op_n       = operacion;
`ifdef SPI_HS_RETRY_EN
                    retry_n    = RETRY_W'(HS_RETRIES);
`endif
                end
            end
            // busy drops after the done cycle; CS stays high one more half-period before IDLE.
            FINISH: begin
                busy_n = 1'b0;
                if (half_end) state_n = IDLE;
                else          div_n   = div_cnt + 1'b1;
            end
`ifdef SPI_HS_RETRY_EN
            HS_WAIT: begin
                if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                    state_n = HS_TX;
                    cs_n    = 1'b0;
                    div_n   = '0;
                    bit_n   = BIT_W'(8);
                    tx_n    = HS_REQ;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
`endif
            default: begin
                if (!half_end) begin
                    div_n = div_cnt + 1'b1;
                end else begin
                    div_n  = '0;
                    sclk_n = ~SCLK;
                    if (!SCLK) begin
                        if (state == HS_RX || state == RX_RES)
                            rx_n = {rx_sr[MAXB-2:0], MISO};
                    end else if (bit_cnt != BIT_W'(1)) begin
                        bit_n = bit_cnt - 1'b1;
                        tx_n  = {tx_sr[6:0], 1'b0};
                    end else begin
                        // Last falling edge of a field: load the next field without a gap.
                        tx_n = '0;
                        case (state)
                            HS_TX: begin
                                state_n = HS_RX;
                                bit_n   = BIT_W'(8);
                            end
                            HS_RX: begin
                                if (rx_sr[7:0] == HS_ACK) begin
                                    led_n   = 1'b1;
                                    state_n = TX_NUM1;
                                    bit_n   = BIT_W'(4);
                                    tx_n    = {n1_q, 4'h0};
                                end else begin
                                    cs_n = 1'b1;
`ifdef SPI_HS_RETRY_EN
                                    if (retry_cnt != '0) begin
                                        retry_n = retry_cnt - 1'b1;
                                        state_n = HS_WAIT;
                                    end else
`endif
                                    begin
                                        hs_error_n = 1'b1;
                                        done_n     = 1'b1;
                                        state_n    = FINISH;
                                    end
                                end
                            end
                            TX_NUM1: begin
                                state_n = TX_NUM2;
                                bit_n   = BIT_W'(4);
                                tx_n    = {n2_q, 4'h0};
                            end
                            TX_NUM2: begin
                                state_n = TX_OP;
                                bit_n   = BIT_W'(2);
                                tx_n    = {op_q, 6'h00};
                            end
                            TX_OP: begin
                                state_n = RX_RES;
                                bit_n   = BIT_W'(RESULT_W);
                            end
                            RX_RES: begin
                                cs_n        = 1'b1;
                                resultado_n = rx_sr[RESULT_W-1:0];
                                done_n      = 1'b1;
                                hs_error_n  = 1'b0;
                                state_n     = FINISH;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_spi_calc_master.sv
// Directed bench for spi_calc_master: CLK_DIV=4 instance for the main scenarios, CLK_DIV=1 instance for fast timing.
`timescale 1ns/1ps
module tb_spi_calc_master;
`ifdef SPI_HS_RETRY_EN
    localparam int ABORT_LAT    = 1 + 134 * 4;
    localparam int ABORT_FRAMES = 4;
`else
    localparam int ABORT_LAT    = 129;
    localparam int ABORT_FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, start_a, start_b;
    logic [3:0] num1, num2;
    logic [1:0] op;
    logic [7:0] s_ack;
    logic [3:0] s_res;

    logic busy_a, done_a, err_a, led_a, sclk_a, cs_a, mosi_a, miso_a;
    logic busy_b, done_b, err_b, led_b, sclk_b, cs_b, mosi_b, miso_b;
    logic [3:0] res_a, res_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_calc_master #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num1(num1), .num2(num2), .operacion(op),
        .busy(busy_a), .done(done_a), .hs_error(err_a), .LED_handshake(led_a), .resultado(res_a),
        .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a));

    spi_calc_master #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num1(num1), .num2(num2), .operacion(op),
        .busy(busy_b), .done(done_b), .hs_error(err_b), .LED_handshake(led_b), .resultado(res_b),
        .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b));

    // Slave frame, bit i of 30: 8 don't-care, ack byte, 10 don't-care, result nibble.
    function automatic logic slave_bit(input int i, input logic [7:0] ack, input logic [3:0] res);
        logic [29:0] v;
        v = {8'h00, ack, 10'h000, res};
        if (i >= 0 && i < 30) return v[29 - i];
        return 1'b0;
    endfunction

    int a_idx = 0, a_frames = 0, a_viol = 0;
    int b_idx = 0, b_frames = 0, b_viol = 0;
    logic [29:0] a_cap = '0, b_cap = '0;
    time a_mchg = 0, b_mchg = 0;

    assign miso_a = slave_bit(a_idx, s_ack, s_res);
    assign miso_b = slave_bit(b_idx, s_ack, s_res);

    always @(mosi_a) a_mchg = $time;
    always @(mosi_b) b_mchg = $time;

    always @(negedge cs_a or posedge sclk_a) begin
        if (sclk_a) begin
            a_cap = {a_cap[28:0], mosi_a};
            a_idx++;
            if ($time - a_mchg < 10) a_viol++;
        end else begin
            a_idx = 0;
            a_frames++;
            a_cap = '0;
        end
    end

    always @(negedge cs_b or posedge sclk_b) begin
        if (sclk_b) begin
            b_cap = {b_cap[28:0], mosi_b};
            b_idx++;
            if ($time - b_mchg < 10) b_viol++;
        end else begin
            b_idx = 0;
            b_frames++;
            b_cap = '0;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done_a(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_a) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done_b(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_b) begin
                t = cyc;
                break;
            end
        end
    endtask

    // Returns on the cycle after acceptance (T0+1).
    task automatic go_a(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o, output int t0);
        @(negedge clk);
        num1 = a; num2 = b; op = o; start_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    function automatic logic [29:0] frame(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        return {8'hAA, 8'h00, a, b, o, 4'h0};
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t, f0, gap, dw;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        num1 = '0; num2 = '0; op = '0; s_ack = 8'hBB; s_res = 4'h9;
        repeat (3) @(negedge clk);
        check("rst_cs", cs_a, 1);        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);    check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);    check("rst_err", err_a, 0);
        check("rst_led", led_a, 0);      check("rst_res", res_a, 0);
        check("rst_b_cs", cs_b, 1);      check("rst_b_res", res_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: nominal transaction
        f0 = a_frames;
        go_a(4'h3, 4'h6, 2'b00, t0);
        check("t1_cs_low", cs_a, 0);
        check("t1_busy", busy_a, 1);
        check("t1_mosi_first", mosi_a, 1);
        wait_done_a(400, t);
        check("t1_latency", t - t0, 241);
        check("t1_res", res_a, 4'h9);
        check("t1_led", led_a, 1);
        check("t1_err", err_a, 0);
        check("t1_cs_done", cs_a, 1);
        check("t1_mosi_stream", a_cap, frame(4'h3, 4'h6, 2'b00));
        check("t1_rises", a_idx, 30);
        @(negedge clk);
        check("t1_done_width", done_a, 0);
        check("t1_busy_drop", busy_a, 0);
        check("t1_frames", a_frames - f0, 1);
        repeat (8) @(negedge clk);

        // 2: handshake mismatch
        s_ack = 8'h5A;
        f0 = a_frames;
        go_a(4'h1, 4'h2, 2'b01, t0);
        wait_done_a(1000, t);
        check("t2_latency", t - t0, ABORT_LAT);
        check("t2_err", err_a, 1);
        check("t2_res_kept", res_a, 4'h9);
        check("t2_led", led_a, 0);
        check("t2_cs", cs_a, 1);
        check("t2_sclk", sclk_a, 0);
        check("t2_frames", a_frames - f0, ABORT_FRAMES);
        repeat (8) @(negedge clk);
        check("t2_err_sticky", err_a, 1);
        s_ack = 8'hBB;

        // 3: start while busy is ignored, inputs changed mid-frame
        s_res = 4'h6;
        f0 = a_frames;
        go_a(4'hA, 4'h5, 2'b11, t0);
        while (cyc < t0 + 50) @(negedge clk);
        start_a = 1'b1; num1 = 4'h0; num2 = 4'hF; op = 2'b00;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(400, t);
        check("t3_latency", t - t0, 241);
        check("t3_mosi_stream", a_cap, frame(4'hA, 4'h5, 2'b11));
        check("t3_res", res_a, 4'h6);
        check("t3_err_cleared", err_a, 0);
        repeat (20) @(negedge clk);
        check("t3_frames", a_frames - f0, 1);
        check("t3_idle", busy_a, 0);

        // 4: reset mid-transfer, then a fresh transaction
        go_a(4'h3, 4'h6, 2'b00, t0);
        while (cyc < t0 + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_cs", cs_a, 1);
        check("t4_sclk", sclk_a, 0);
        check("t4_busy", busy_a, 0);
        check("t4_done", done_a, 0);
        check("t4_res", res_a, 0);
        dw = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a) dw++;
        end
        check("t4_no_done", dw, 0);
        s_res = 4'hA;
        go_a(4'h5, 4'h5, 2'b01, t0);
        wait_done_a(400, t);
        check("t4_latency", t - t0, 241);
        check("t4_res_new", res_a, 4'hA);
        check("t4_mosi_stream", a_cap, frame(4'h5, 4'h5, 2'b01));
        repeat (8) @(negedge clk);

        // 6: start held high, two frames back to back
        s_res = 4'h3;
        f0 = a_frames;
        @(negedge clk);
        num1 = 4'hC; num2 = 4'h1; op = 2'b10; start_a = 1'b1;
        t0 = cyc;
        wait_done_a(400, t);
        check("t6_latency1", t - t0, 241);
        gap = 0; dw = 0;
        for (int i = 0; i < 50 && cs_a; i++) begin
            @(negedge clk);
            if (done_a) dw++;
            gap++;
        end
        check("t6_cs_gap", gap >= 4 && gap < 50, 1);
        check("t6_done_width1", dw, 0);
        t0 = cyc - 1;
        wait_done_a(400, t);
        check("t6_latency2", t - t0, 241);
        @(negedge clk);
        start_a = 1'b0;
        check("t6_done_width2", done_a, 0);
        repeat (12) @(negedge clk);
        check("t6_frames", a_frames - f0, 2);
        check("t6_res", res_a, 4'h3);
        check("a_protocol", a_viol, 0);

        // 5: CLK_DIV=1 instance
        s_res = 4'h5;
        f0 = b_frames;
        @(negedge clk);
        num1 = 4'h7; num2 = 4'h2; op = 2'b10; start_b = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        check("t5_cs_low", cs_b, 0);
        wait_done_b(200, t);
        check("t5_latency", t - t0, 61);
        check("t5_res", res_b, 4'h5);
        check("t5_led", led_b, 1);
        check("t5_mosi_stream", b_cap, frame(4'h7, 4'h2, 2'b10));
        check("t5_rises", b_idx, 30);
        repeat (4) @(negedge clk);
        check("t5_frames", b_frames - f0, 1);
        check("b_protocol", b_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
